// File: rtl/uncache_bridge.sv
// Uncached data-port bridge: turns one core data-SRAM access into a single-beat
// AXI read or write, stalling the core until the bus transaction completes.
module uncache_bridge #(
    parameter int ID_W = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            data_sram_en,
    input  logic [3:0]      data_sram_wen,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    output logic            stallreq_uncache,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic            awvalid,
    input  logic            awready,

    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR,
        WR_B,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wen_q;
    logic [31:0] rdata_q;
    logic        aw_done;
    logic        w_done;
    logic        aw_fire;
    logic        w_fire;
    logic        unused_resp;

    // Response status and IDs are deliberately ignored; every access completes normally.
    assign unused_resp = ^{rid, rresp, rlast, bid, bresp};

    assign aw_fire = (state == WR) && !aw_done && awready;
    assign w_fire  = (state == WR) && !w_done  && wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= '0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && data_sram_en) begin
                addr_q  <= data_sram_addr;
                wdata_q <= data_sram_wdata;
                wen_q   <= data_sram_wen;
            end
            if (state == RD_D && rvalid) begin
                rdata_q <= rdata;
            end
            // Done flags only live while in WR; they clear as the write leaves WR.
            if (state == WR && state_next == WR) begin
                aw_done <= aw_done | aw_fire;
                w_done  <= w_done  | w_fire;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (state)
            IDLE: begin
                if (data_sram_en) begin
                    state_next = (data_sram_wen == 4'b0000) ? RD_A : WR;
                end
            end
            RD_A: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = RD_D;
                end
            end
            RD_D: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = DONE;
                end
            end
            WR: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_next = WR_B;
                end
            end
            WR_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        case (wen_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize = 3'b000;
            4'b0011, 4'b1100:                   awsize = 3'b001;
            default:                            awsize = 3'b010;
        endcase
    end

    // Stall is forced low while reset is held, even if the core presents a request.
    assign stallreq_uncache = rst && ((state == IDLE && data_sram_en) ||
                                      state == RD_A || state == RD_D ||
                                      state == WR   || state == WR_B);

    assign data_sram_rdata = rdata_q;

    assign arid   = '0;
    assign araddr = {addr_q[31:2], 2'b00};
    assign arlen  = '0;
    assign arsize = 3'b010;

    assign awid   = '0;
    assign awaddr = addr_q;
    assign awlen  = '0;

    assign wdata  = wdata_q;
    assign wstrb  = wen_q;
    assign wlast  = 1'b1;

endmodule

// File: tb/tb_uncache_bridge.sv
// Self-checking bench for uncache_bridge: table of core accesses against a
// delay-programmable AXI slave, with queue-based scoreboarding of every handshake.
module tb_uncache_bridge;

    logic        clk;
    logic        rst;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq_uncache;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    uncache_bridge #(.ID_W(4)) dut (
        .clk(clk), .rst(rst),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .stallreq_uncache(stallreq_uncache),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        gap;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_val;
        int unsigned ar_d;
        int unsigned r_d;
        int unsigned aw_d;
        int unsigned w_d;
        int unsigned b_d;
        logic [31:0] exp_araddr;
        logic [2:0]  exp_size;
        logic [31:0] exp_rdata;
        int unsigned exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
    } aw_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;
    int unsigned e_ar = 0, e_r = 0, e_aw = 0, e_w = 0, e_b = 0;
    int unsigned ar_d = 0, r_d = 0, aw_d = 0, w_d = 0, b_d = 0;
    logic [31:0] rdata_val = '0;

    logic [31:0] ar_q[$];
    aw_exp_t     aw_q[$];
    w_exp_t      w_q[$];
    logic [31:0] rd_q[$];

    vec_t vecs[10];
    vec_t post_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: handshake with empty scoreboard queue", name);
    endtask

    // AXI slave: each ready/valid rises after the programmed number of waiting cycles.
    int unsigned ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
    initial begin
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rdata = '0; rresp = 2'b10; rid = 4'h5; rlast = 1'b1;
        bvalid = 1'b0; bresp = 2'b11; bid = 4'h5;
        forever begin
            @(posedge clk); #1;
            if (arvalid) begin arready = (ar_c >= ar_d); ar_c++; end
            else begin arready = 1'b0; ar_c = 0; end
            if (awvalid) begin awready = (aw_c >= aw_d); aw_c++; end
            else begin awready = 1'b0; aw_c = 0; end
            if (wvalid) begin wready = (w_c >= w_d); w_c++; end
            else begin wready = 1'b0; w_c = 0; end
            if (rready) begin rvalid = (r_c >= r_d); rdata = rdata_val; r_c++; end
            else begin rvalid = 1'b0; r_c = 0; end
            if (bready) begin bvalid = (b_c >= b_d); b_c++; end
            else begin bvalid = 1'b0; b_c = 0; end
        end
    end

    // Monitor: scoreboard pops on handshakes, plus valid/payload stability checks.
    logic        ar_pend = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;
    logic        aw_fired = 1'b0, w_fired = 1'b0;
    logic [31:0] ar_hold, aw_hold, w_hold;
    logic [3:0]  strb_hold;
    always @(negedge clk) begin
        if (!rst) begin
            ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
            aw_fired = 1'b0; w_fired = 1'b0;
        end else begin
            if (ar_pend) begin
                chk("arvalid_held", 32'(arvalid), 32'd1);
                chk("araddr_stable", araddr, ar_hold);
            end
            if (aw_pend) begin
                chk("awvalid_held", 32'(awvalid), 32'd1);
                chk("awaddr_stable", awaddr, aw_hold);
            end
            if (w_pend) begin
                chk("wvalid_held", 32'(wvalid), 32'd1);
                chk("wdata_stable", wdata, w_hold);
                chk("wstrb_stable", 32'(wstrb), 32'(strb_hold));
            end
            if (aw_fired) chk("awvalid_drop", 32'(awvalid), 32'd0);
            if (w_fired)  chk("wvalid_drop", 32'(wvalid), 32'd0);

            if (arvalid && arready) begin
                n_ar++;
                if (ar_q.size() == 0) unexpected("ar_extra");
                else begin
                    chk("araddr", araddr, ar_q.pop_front());
                    chk("arsize", 32'(arsize), 32'd2);
                    chk("arlen_arid", {arlen, 20'd0, arid}, 32'd0);
                end
            end
            if (awvalid && awready) begin
                n_aw++;
                if (aw_q.size() == 0) unexpected("aw_extra");
                else begin
                    aw_exp_t e;
                    e = aw_q.pop_front();
                    chk("awaddr", awaddr, e.addr);
                    chk("awsize", 32'(awsize), 32'(e.size));
                    chk("awlen_awid", {awlen, 20'd0, awid}, 32'd0);
                end
            end
            if (wvalid && wready) begin
                n_w++;
                if (w_q.size() == 0) unexpected("w_extra");
                else begin
                    w_exp_t e;
                    e = w_q.pop_front();
                    chk("wdata", wdata, e.data);
                    chk("wstrb", 32'(wstrb), 32'(e.strb));
                    chk("wlast", 32'(wlast), 32'd1);
                end
            end
            if (rvalid && rready) n_r++;
            if (bvalid && bready) n_b++;

            ar_pend = arvalid && !arready; ar_hold = araddr;
            aw_pend = awvalid && !awready; aw_hold = awaddr;
            w_pend  = wvalid && !wready;   w_hold = wdata; strb_hold = wstrb;
            aw_fired = awvalid && awready;
            w_fired  = wvalid && wready;
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int unsigned cyc;
        ar_d = v.ar_d; r_d = v.r_d; aw_d = v.aw_d; w_d = v.w_d; b_d = v.b_d;
        rdata_val = v.rdata_val;
        if (v.gap) begin
            @(posedge clk); #1;
            data_sram_en = 1'b0;
        end
        @(posedge clk); #1;
        if (v.wr) begin
            aw_q.push_back('{addr: v.addr, size: v.exp_size});
            w_q.push_back('{data: v.wdata, strb: v.wen});
            e_aw++; e_w++; e_b++;
        end else begin
            ar_q.push_back(v.exp_araddr);
            e_ar++; e_r++;
        end
        rd_q.push_back(v.exp_rdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = v.wen;
        data_sram_addr  = v.addr;
        data_sram_wdata = v.wdata;
        cyc = 0;
        @(negedge clk);
        while (stallreq_uncache && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_stall_cycles"}, cyc, v.exp_stall);
        chk({tag, "_rdata"}, data_sram_rdata, rd_q.pop_front());
        chk({tag, "_ar_count"}, n_ar, e_ar);
        chk({tag, "_r_count"},  n_r,  e_r);
        chk({tag, "_aw_count"}, n_aw, e_aw);
        chk({tag, "_w_count"},  n_w,  e_w);
        chk({tag, "_b_count"},  n_b,  e_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        //          wr    gap   wen      addr           wdata          rdata_val      ar r  aw w  b  exp_araddr     size    exp_rdata      stall
        vecs[0] = '{1'b0, 1'b1, 4'b0000, 32'h1FAF_F004, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h1FAF_F004, 3'd2, 32'hDEAD_BEEF, 3};
        vecs[1] = '{1'b1, 1'b0, 4'b0100, 32'h1FAF_F002, 32'h00AB_0000, 32'h0,         0, 0, 0, 0, 0, 32'h0,         3'd0, 32'hDEAD_BEEF, 3};
        vecs[2] = '{1'b1, 1'b1, 4'b1111, 32'h8000_0010, 32'h1234_5678, 32'h0,         0, 0, 3, 0, 2, 32'h0,         3'd2, 32'hDEAD_BEEF, 8};
        vecs[3] = '{1'b0, 1'b1, 4'b0000, 32'h1FD0_0003, 32'h0,         32'hA5A5_5A5A, 10, 0, 0, 0, 0, 32'h1FD0_0000, 3'd2, 32'hA5A5_5A5A, 13};
        vecs[4] = '{1'b0, 1'b1, 4'b0000, 32'h0000_0100, 32'h0,         32'h1111_2222, 0, 0, 0, 0, 0, 32'h0000_0100, 3'd2, 32'h1111_2222, 3};
        vecs[5] = '{1'b0, 1'b0, 4'b0000, 32'h0000_0104, 32'h0,         32'h3333_4444, 0, 0, 0, 0, 0, 32'h0000_0104, 3'd2, 32'h3333_4444, 3};
        vecs[6] = '{1'b1, 1'b1, 4'b0011, 32'hBFC0_0000, 32'h0000_BEEF, 32'h0,         0, 0, 1, 2, 0, 32'h0,         3'd1, 32'h3333_4444, 5};
        vecs[7] = '{1'b1, 1'b1, 4'b1100, 32'hBFC0_0002, 32'hBEEF_0000, 32'h0,         0, 0, 2, 2, 1, 32'h0,         3'd1, 32'h3333_4444, 6};
        vecs[8] = '{1'b1, 1'b0, 4'b0001, 32'h1FAF_F000, 32'h0000_0055, 32'h0,         0, 0, 0, 4, 0, 32'h0,         3'd0, 32'h3333_4444, 7};
        vecs[9] = '{1'b0, 1'b1, 4'b0000, 32'h1FAF_F008, 32'h0,         32'hCAFE_F00D, 0, 3, 0, 0, 0, 32'h1FAF_F008, 3'd2, 32'hCAFE_F00D, 6};
        post_rst = '{1'b0, 1'b1, 4'b0000, 32'h1FAF_F00C, 32'h0,        32'h0BAD_F00D, 0, 0, 0, 0, 0, 32'h1FAF_F00C, 3'd2, 32'h0BAD_F00D, 3};

        // Reset with a request already presented: stall must stay low.
        rst = 1'b0;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000;
        data_sram_addr = 32'h1FAF_F004; data_sram_wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("reset_stall", 32'(stallreq_uncache), 32'd0);
        chk("reset_rdata", data_sram_rdata, 32'd0);
        data_sram_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset pulse while waiting in the read-data phase.
        ar_d = 0; r_d = 5; rdata_val = 32'h7777_8888;
        @(posedge clk); #1;
        data_sram_en = 1'b0;
        @(posedge clk); #1;
        ar_q.push_back(32'h1000_0000); e_ar++;
        data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h1000_0000;
        cyc = 0;
        @(negedge clk);
        while (!rready && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        chk("rst_mid_reached_rd_d", 32'(rready), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst_mid_stall", 32'(stallreq_uncache), 32'd0);
        chk("rst_mid_rdata", data_sram_rdata, 32'd0);
        repeat (2) @(negedge clk);
        data_sram_en = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {30'd0, rready, stallreq_uncache}, 32'd0);
        chk("post_rst_r_count", n_r, e_r);

        run_vec(post_rst, "post_rst");

        @(posedge clk); #1;
        data_sram_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_stall", 32'(stallreq_uncache), 32'd0);
        chk("queues_drained", 32'(ar_q.size() + aw_q.size() + w_q.size() + rd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uncache_bridge.md
UNCACHE_BRIDGE -- requirements
Module: uncache_bridge

Interface
REQ-001 SHALL have parameter ID_W, default 4, meaning the AXI ID width; all issued IDs SHALL be 0.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports data_sram_en/wen/addr/wdata  input  1/4/32/32  core-side request: wen==0 means read; addr is physical.
REQ-005 SHALL have port data_sram_rdata  output  32  read data returned to the core.
REQ-006 SHALL have port stallreq_uncache  output  1  holds the core pipeline until the access completes.
REQ-007 SHALL have AXI read ports: arid(ID_W), araddr(32), arlen(8), arsize(3), arvalid out; arready in; rid, rdata(32), rresp(2), rlast, rvalid in; rready out.
REQ-008 SHALL have AXI write ports: awid, awaddr, awlen, awsize, awvalid out; awready in; wdata(32), wstrb(4), wlast, wvalid out; wready in; bid, bresp, bvalid in; bready out.

Function
REQ-009 SHALL implement states IDLE, RD_A, RD_D, WR, WR_B, DONE.
REQ-010 In IDLE, en=1 and wen==0 SHALL latch addr and go to RD_A; en=1 and wen!=0 SHALL latch addr/wdata/wen and go to WR.
REQ-011 stallreq_uncache SHALL be 1 when (IDLE and en=1) or state in {RD_A, RD_D, WR, WR_B}, and 0 otherwise (combinational).
REQ-012 RD_A: arvalid=1, araddr = latched addr with bits [1:0] forced to 0, arsize=3'b010, arlen=0; on arready, go to RD_D.
REQ-013 RD_D: rready=1; on rvalid, capture rdata into the rdata register and go to DONE.
REQ-014 WR: awvalid and wvalid SHALL be raised together and dropped independently at their own handshakes (aw_done/w_done flags); go to WR_B once both are done, including when both complete in the same cycle.
REQ-015 awaddr SHALL be the latched addr; awsize = 0 for one-hot wen, 1 for 4'b0011/4'b1100, 2 for 4'b1111; wstrb = latched wen; wlast=1; awlen=0.
REQ-016 WR_B: bready=1; on bvalid, go to DONE.
REQ-017 DONE SHALL last exactly one cycle with stallreq_uncache=0 and SHALL return to IDLE without re-sampling en in that cycle.
REQ-018 data_sram_rdata SHALL be the rdata register, held until the next R handshake.
REQ-019 rresp/bresp error codes, rid and bid SHALL be ignored; the access completes normally.
REQ-020 Valid outputs SHALL remain asserted, with stable payload, until their handshake completes.
REQ-021 Minimum read latency SHALL be 3 cycles from request to DONE (arready and rvalid each asserted immediately).
REQ-022 Only one transaction SHALL be outstanding at any time.

Reset
REQ-023 While rst=0: state=IDLE; all valid/ready outputs, aw_done/w_done, the rdata register and stallreq_uncache SHALL be 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction immediately; no response is awaited after release.

Verification
REQ-025 Read: en=1, wen=0, addr=0x1FAF_F004; arready=1, rvalid=1 with rdata=0xDEAD_BEEF one cycle later -> araddr=0x1FAF_F004, arsize=2, stall high for 3 cycles, DONE, rdata=0xDEAD_BEEF.
REQ-026 Byte write: wen=4'b0100, addr=0x1FAF_F002, wdata=0x00AB_0000 -> awsize=0, wstrb=4'b0100, stall released one cycle after bvalid.
REQ-027 Skewed write handshake: wready 3 cycles before awready -> wvalid drops after its handshake, awvalid held, single B wait, single DONE.
REQ-028 Backpressure: arready held 0 for 10 cycles -> arvalid and araddr stable throughout, stallreq_uncache=1.
REQ-029 Back-to-back: new request on the cycle after DONE -> exactly two AR handshakes, no duplicate issue.
REQ-030 Reset pulse during RD_D -> outputs return to reset values, IDLE after release, next request works.
